// File: rtl/burst_line_responder.sv
// burst_line_responder
// Fills one cache line by issuing N single-word reads to a word memory and
// assembling the returned words into a wide line. Issue and collection
// overlap. All outputs are registered.
//
// Handshake: av_read is sampled in IDLE or RESP. av_wait_data rises at that
// same edge and stays high until the line is complete. mem_read is held with
// a stable mem_address until a cycle with mem_waitrequest=0 accepts it.
// mem_readdatavalid may arrive any cycle after acceptance, in issue order.
module burst_line_responder #(
    parameter int BURST      = 4,
    parameter int LINE_WIDTH = BURST * 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           av_address,
    input  logic                  av_read,
    input  logic                  av_write,
    input  logic [LINE_WIDTH-1:0] av_writedata,
    input  logic [2:0]            av_burstcount,
    output logic                  av_wait_data,
    output logic [LINE_WIDTH-1:0] av_reddata,
    output logic                  write_ready_n,
    output logic [31:0]           mem_address,
    output logic                  mem_read,
    input  logic                  mem_waitrequest,
    input  logic [31:0]           mem_readdata,
    input  logic                  mem_readdatavalid
);

    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           base_q, base_d;
    logic [CW-1:0]         n_q, n_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         received_q, received_d;
    logic                  wait_q, wait_d;
    logic                  mem_read_q, mem_read_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [CW-1:0]         req_n;

    // Writes are never accepted; these inputs only exist for bus compatibility.
    logic unused_inputs;
    assign unused_inputs = ^{av_write, av_writedata, av_address[3:0]};

    assign write_ready_n = 1'b1;
    assign av_wait_data  = wait_q;
    assign av_reddata    = line_q;
    assign mem_address   = mem_addr_q;
    assign mem_read      = mem_read_q;

    // Out-of-range burst counts (0 or above BURST) fall back to a full line.
    always_comb begin
        req_n = CW'(BURST);
        if (av_burstcount != 3'd0 && int'(av_burstcount) <= BURST) begin
            req_n = CW'(av_burstcount);
        end
    end

    // Next-state and next-output logic for the fill sequencer.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        n_d        = n_q;
        issued_d   = issued_q;
        received_d = received_q;
        wait_d     = wait_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        line_d     = line_q;
        case (state_q)
            IDLE, RESP: begin
                // RESP lasts one cycle but accepts a new request like IDLE.
                state_d = IDLE;
                if (av_read) begin
                    state_d    = FETCH;
                    base_d     = {av_address[31:4], 4'b0000};
                    n_d        = req_n;
                    issued_d   = '0;
                    received_d = '0;
                    wait_d     = 1'b1;
                    line_d     = '0;
                    mem_read_d = 1'b1;
                    mem_addr_d = {av_address[31:4], 4'b0000};
                end
            end
            FETCH: begin
                // Issue side: advance only on an accepted request.
                if (mem_read_q && !mem_waitrequest) begin
                    issued_d = issued_q + CW'(1);
                    if (issued_d == n_q) begin
                        mem_read_d = 1'b0;
                    end else begin
                        mem_addr_d = base_q + {{(30 - CW){1'b0}}, issued_d, 2'b00};
                    end
                end
                // Collect side: extra beats beyond N are dropped.
                if (mem_readdatavalid && received_q != n_q) begin
                    line_d[int'(received_q) * 32 +: 32] = mem_readdata;
                    received_d = received_q + CW'(1);
                    if (received_d == n_q) begin
                        state_d = RESP;
                        wait_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any fill in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            n_q        <= '0;
            issued_q   <= '0;
            received_q <= '0;
            wait_q     <= 1'b0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            n_q        <= n_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            wait_q     <= wait_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            line_q     <= line_d;
        end
    end

endmodule

// File: doc/burst_line_responder.md
BURST_LINE_RESPONDER -- requirements
Module: burst_line_responder

Interface
REQ-001 SHALL have parameter BURST, default 4, meaning words per line fill.
REQ-002 SHALL have parameter LINE_WIDTH, default BURST*32, meaning width of the line data bus.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port av_address  input  32  line request byte address from the cache master.
REQ-006 SHALL have port av_read  input  1  read request strobe.
REQ-007 SHALL have port av_write  input  1  write strobe; ignored.
REQ-008 SHALL have port av_writedata  input  LINE_WIDTH  ignored.
REQ-009 SHALL have port av_burstcount  input  3  requested words per fill.
REQ-010 SHALL have port av_wait_data  output  1  busy; the line is not yet valid.
REQ-011 SHALL have port av_reddata  output  LINE_WIDTH  assembled line, word 0 in bits [31:0].
REQ-012 SHALL have port write_ready_n  output  1  constant 1; writes never accepted.
REQ-013 SHALL have port mem_address  output  32  word-memory byte address.
REQ-014 SHALL have port mem_read  output  1  word read request.
REQ-015 SHALL have port mem_waitrequest  input  1  word memory stalls the request.
REQ-016 SHALL have port mem_readdata  input  32  returned word.
REQ-017 SHALL have port mem_readdatavalid  input  1  mem_readdata valid this cycle.

Function
REQ-018 SHALL implement states IDLE, FETCH, RESP, all registered outputs.
REQ-019 In IDLE with av_read=1, SHALL latch base = {av_address[31:4],4'b0} and count N, set av_wait_data=1 at the same edge, clear av_reddata, and enter FETCH.
REQ-020 N SHALL equal av_burstcount when 1..BURST; 0 or >BURST SHALL give N=BURST.
REQ-021 av_wait_data SHALL be 1 in the cycle immediately after the cycle av_read was first sampled high; zero-cycle gap is mandatory.
REQ-022 In FETCH, SHALL hold mem_read=1 with mem_address = base + 4*issued; issued increments only in a cycle with mem_read=1 and mem_waitrequest=0; mem_read drops after N accepted issues.
REQ-023 Issue and collection SHALL overlap; each mem_readdatavalid=1 writes mem_readdata into lane "received" of av_reddata and increments received.
REQ-024 Issued and received counters SHALL be width clog2(BURST)+1, never wrap; a mem_readdatavalid with received==N SHALL be ignored.
REQ-025 When received reaches N, SHALL enter RESP and drive av_wait_data=0 at that edge; lanes >=N remain 0.
REQ-026 av_reddata SHALL stay stable from RESP until the next accepted request.
REQ-027 RESP SHALL last one cycle, then IDLE; av_read=1 during RESP SHALL be accepted as a new request exactly as in IDLE.
REQ-028 av_read during FETCH SHALL be ignored; no queuing.
REQ-029 av_write=1 SHALL have no effect in any state.
REQ-030 Fill latency SHALL be 1 + N + memory latency cycles minimum (1 cycle per word with mem_waitrequest=0 and one-cycle readdatavalid).

Reset
REQ-031 On reset=1 at an edge: state=IDLE, av_wait_data=0, av_reddata=0, mem_read=0, mem_address=0, counters=0; write_ready_n=1 always.
REQ-032 Reset during FETCH SHALL abort the fill; subsequent stray mem_readdatavalid in IDLE SHALL be ignored.
REQ-033 av_read while reset=1 SHALL not be accepted.

Verification
REQ-034 av_address=0x0000_1234, av_burstcount=4, zero-wait memory returning addr+0xA000 -> mem_address 0x1230,0x1234,0x1238,0x123C; av_reddata={0xB23C,0xB238,0xB234,0xB230}; av_wait_data high next cycle after av_read.
REQ-035 mem_waitrequest high 3 cycles on the second issue -> mem_address held 0x1234 for 4 cycles, no duplicate issue, correct line returned.
REQ-036 av_burstcount=2 -> two issues only, lanes 2-3 =0; av_burstcount=0 -> four issues.
REQ-037 Reset asserted after 2 words returned -> next cycle av_wait_data=0, mem_read=0, av_reddata=0; two late readdatavalid pulses leave av_reddata=0.
REQ-038 Back-to-back fills: new av_read in RESP cycle -> accepted, av_wait_data=1 next cycle, new base latched.
REQ-039 av_write=1 with av_writedata all-ones in every state -> no memory traffic, write_ready_n=1, outputs unchanged.
